rv_decode_stage: RTL and testbench
==================================

# rv_decode_stage

Registered, parametrised instruction-decode pipeline stage between fetch and execute. Each accepted instruction word and its PC produce one registered decode bundle: register indices, funct fields, a full-width sign-extended immediate with correct B/J bit placement, a format class and an illegal-instruction flag. Both sides use valid/ready handshakes, and a flush clears the stage. It replaces the purely combinational field splitter.

## Interface
- XLEN, 32, datapath width for `imm_o` and `pc_i`/`pc_o`; legal values are 32 or 64.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all held and incoming instructions.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept this cycle.
- instr_i  in  32  instruction word.
- pc_i  in  XLEN  instruction address.
- valid_o  out  1  decode bundle valid.
- ready_i  in  1  downstream accepts the bundle.
- pc_o  out  XLEN  PC of the bundle.
- opcode_o  out  7  instr[6:0].
- rd_o / rs1_o / rs2_o  out  5 each  instr[11:7] / [19:15] / [24:20].
- funct3_o  out  3  instr[14:12].
- funct7_o  out  7  instr[31:25].
- imm_o  out  XLEN  sign-extended immediate.
- fmt_o  out  3  format class: NONE=0, R=1, I=2, S=3, B=4, U=5, J=6.
- illegal_o  out  1  opcode not implemented or instr[1:0] != 2'b11.

## Operation
- Transfer in when `valid_i && ready_o`. Transfer out when `valid_o && ready_i`.
- Opcode map:
  - OP 0110011 → R.
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011, FENCE 0001111 → I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111, AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - Any other opcode → fmt NONE, imm 0, `illegal_o` = 1.
- Immediates, each sign-extended from bit 31 to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R → 0.
- Field outputs are passed through unconditionally, regardless of format.
- Flush: the next edge clears every valid flag and any skid entry. An instruction offered in the flush cycle is dropped, even if `ready_o` is high. Flush wins over all simultaneous events.
- Reset values: valid_o=0, all payload outputs 0, fmt_o=NONE, illegal_o=0, skid empty, ready_o=1.
- Reset asserted mid-operation discards everything immediately (asynchronous).

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented on `valid_o` after edge N.
- Payload is held stable while `valid_o && !ready_i`.
- Throughput is one instruction per cycle when `ready_i` is held high.
- Without the skid option, `ready_o = !valid_o || ready_i` (combinational path).
- With the skid option, `ready_o` is a flop output: `ready_o = !skid_valid`.
  - An instruction accepted while the output is stalled is decoded into the skid entry.
  - On the next output transfer, the skid entry moves to the output register and `ready_o` rises on the following cycle.
  - Full condition: output valid and skid valid. In that state `ready_o` = 0 and no instruction is lost.

## Configuration
- `RV_DECODE_SKID_EN` defined: a 2-entry skid buffer. `ready_o` is registered, which breaks the combinational ready path from execute to fetch, and full throughput is kept under single-cycle stalls.
- Not defined: single output register, with `ready_o` combinational as above.
- Decode results are identical in both modes. Only `ready_o` timing differs.

## Structure
- Shared package `rv_pkg` holds:
  - opcode constants: OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_FENCE;
  - the `fmt_e` enum with the values above;
  - the decode-bundle struct type.
- Sub-module `rv_imm_gen` is purely combinational: instr and XLEN in; imm, fmt and illegal out. It is instantiated once in front of the register or skid logic.

## Test plan
- 0xFFF00093 (ADDI x1,x0,-1), XLEN=32 → rd_o=1, rs1_o=0, fmt_o=I, imm_o=0xFFFFFFFF, illegal_o=0. With XLEN=64 → imm_o=0xFFFFFFFFFFFFFFFF.
- 0xFE20AC23 (SW x2,-8(x1)) → fmt_o=S, rs1_o=1, rs2_o=2, funct3_o=2, imm_o=0xFFFFFFF8.
- 0xFFDFF06F (JAL x0,-4) → fmt_o=J, imm_o=0xFFFFFFFC; 0x12345037 (LUI) → fmt_o=U, imm_o=0x12345000.
- 0x00000000 → illegal_o=1, fmt_o=NONE, imm_o=0, valid_o=1.
- Stream of 4 instructions with `ready_i` low for 3 cycles:
  - no loss and no duplication; order preserved;
  - with the skid option, `ready_o` drops exactly one cycle after the second accept.
- Assert `flush_i` with the output valid, the skid full and `valid_i` high → next cycle valid_o=0 and ready_o=1; the flushed instructions never appear on the output.
- Assert `rst_ni` low mid-stall → outputs are at reset values before the next clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: RISC-V opcode constants, decode format enum and registered decode bundle type
package rv_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
  } dec_t;
endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational format classifier and sign-extended immediate builder (instr in; imm, fmt, illegal out)
module rv_imm_gen import rv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);
  logic [6:0]  op;
  logic [31:0] i32;
  assign op = instr[6:0];
  assign fmt = op == OPC_OP ? FMT_R :
               (op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_JALR ||
                op == OPC_SYSTEM || op == OPC_FENCE) ? FMT_I :
               op == OPC_STORE ? FMT_S :
               op == OPC_BRANCH ? FMT_B :
               (op == OPC_LUI || op == OPC_AUIPC) ? FMT_U :
               op == OPC_JAL ? FMT_J : FMT_NONE;
  assign illegal = fmt == FMT_NONE;
  assign i32 = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
               fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               fmt == FMT_U ? {instr[31:12], 12'b0} :
               fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
               32'd0;
  assign imm = XLEN'($signed(i32));
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered valid/ready decode stage (fetch in: instr_i/pc_i, execute out: fields/imm_o/fmt_o/illegal_o); RV_DECODE_SKID_EN adds a skid entry and registered ready_o
module rv_decode_stage import rv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);
  dec_t            d_in, d_q;
  fmt_e            fmt_in;
  logic            ill_in, take;
  logic [XLEN-1:0] imm_in, imm_q, pc_q;
  rv_imm_gen #(.XLEN(XLEN)) u_imm (
    .instr   (instr_i),
    .imm     (imm_in),
    .fmt     (fmt_in),
    .illegal (ill_in)
  );
  assign d_in = '{opcode: instr_i[6:0], rd: instr_i[11:7], rs1: instr_i[19:15], rs2: instr_i[24:20],
                  funct3: instr_i[14:12], funct7: instr_i[31:25], fmt: fmt_in, illegal: ill_in};
  assign {opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o} = {d_q.opcode, d_q.rd, d_q.rs1, d_q.rs2, d_q.funct3, d_q.funct7};
  assign fmt_o = d_q.fmt;
  assign illegal_o = d_q.illegal;
  assign pc_o = pc_q;
  assign imm_o = imm_q;
  assign take = valid_i && ready_o && !flush_i;
`ifdef RV_DECODE_SKID_EN
  dec_t            d_s;
  logic [XLEN-1:0] imm_s, pc_s;
  logic            skid_v;
  assign ready_o = !skid_v;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_o <= 1'b0;
      skid_v <= 1'b0;
      {d_q, pc_q, imm_q} <= '0;
      {d_s, pc_s, imm_s} <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      skid_v <= 1'b0;
    end else if (!valid_o || ready_i) begin
      valid_o <= skid_v || take;
      skid_v <= 1'b0;
      if (skid_v) {d_q, pc_q, imm_q} <= {d_s, pc_s, imm_s};
      else if (take) {d_q, pc_q, imm_q} <= {d_in, pc_i, imm_in};
    end else if (take) begin
      skid_v <= 1'b1;
      {d_s, pc_s, imm_s} <= {d_in, pc_i, imm_in};
    end
`else
  assign ready_o = !valid_o || ready_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_o <= 1'b0;
      {d_q, pc_q, imm_q} <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (ready_o) begin
      valid_o <= take;
      if (take) {d_q, pc_q, imm_q} <= {d_in, pc_i, imm_in};
    end
`endif
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: scoreboard bench for rv_decode_stage with directed decode vectors, stalls, flush and async reset
`timescale 1ns/1ps
module tb_rv_decode_stage;
  localparam int XLEN = 32;
  localparam int NV = 16;
  logic clk = 1'b0, rst_ni = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [XLEN-1:0] pc_i = '0;
  logic ready_o, valid_o, illegal_o;
  logic [XLEN-1:0] pc_o, imm_o;
  logic [6:0] opcode_o, funct7_o;
  logic [4:0] rd_o, rs1_o, rs2_o;
  logic [2:0] funct3_o, fmt_o;
  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      fmt;
    logic [63:0]     imm;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, seq = 0;
  logic [31:0] v_ins [NV] = '{32'hFFF00093, 32'hFE20AC23, 32'hFFDFF06F, 32'h12345037,
                              32'h00000000, 32'h002081B3, 32'hFE208EE3, 32'h00000463,
                              32'h000000E3, 32'h001000EF, 32'h00000010, 32'h00432283,
                              32'h80000017, 32'h7FF00093, 32'h0000000F, 32'h00000073};
  logic [2:0] v_fmt [NV] = '{3'd2, 3'd3, 3'd6, 3'd5, 3'd0, 3'd1, 3'd4, 3'd4,
                             3'd4, 3'd6, 3'd0, 3'd2, 3'd5, 3'd2, 3'd2, 3'd2};
  logic [63:0] v_imm [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                              64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h8,
                              64'h800, 64'h800, 64'h0, 64'h4,
                              64'hFFFFFFFF80000000, 64'h7FF, 64'h0, 64'h0};
  always #5 clk = ~clk;
  rv_decode_stage #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o)
  );
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  task automatic send(input int k);
    instr_i = v_ins[k];
    pc_i = XLEN'(32'h1000 + 4 * seq);
    seq++;
    valid_i = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ready_o) begin
        q.push_back(exp_t'{instr_i, pc_i, v_fmt[k], v_imm[k]});
        @(posedge clk);
        #1 valid_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    chk("send_timeout", 1, 0);
  endtask
  exp_t e;
  always @(negedge clk)
    if (rst_ni && valid_o && ready_i) begin
      if (q.size() == 0) chk("spurious_out", {pc_o, imm_o}, 0);
      else begin
        e = q.pop_front();
        chk($sformatf("out_%08h", e.instr),
            {pc_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, imm_o, fmt_o, illegal_o},
            {e.pc, e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12],
             e.instr[31:25], e.imm[XLEN-1:0], e.fmt, e.fmt == 3'd0});
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_fmt_ill", {fmt_o, illegal_o}, 0);
    chk("rst_payload", {pc_o, imm_o, opcode_o, rd_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    ready_i = 1'b1;
    for (int k = 0; k < NV; k++) send(k);
    repeat (3) @(posedge clk);
    #1 chk("drain_stream", q.size(), 0);
    ready_i = 1'b0;
    fork
      for (int k = 0; k < 4; k++) send(k + 5);
      begin
        @(negedge clk);
        @(negedge clk);
`ifdef RV_DECODE_SKID_EN
        chk("stall_ready_c1", ready_o, 1);
`else
        chk("stall_ready_c1", ready_o, 0);
`endif
        chk("hold_pc_c1", pc_o, 32'h1040);
        @(negedge clk);
        chk("stall_ready_c2", ready_o, 0);
        chk("hold_pc_c2", pc_o, 32'h1040);
        @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 chk("drain_stall", q.size(), 0);
    ready_i = 1'b0;
    send(0);
`ifdef RV_DECODE_SKID_EN
    send(1);
`endif
    instr_i = v_ins[2];
    pc_i = XLEN'(32'hDEAD0000);
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    valid_i = 1'b0;
    q.delete();
    @(negedge clk);
    chk("flush_valid", valid_o, 0);
    chk("flush_ready", ready_o, 1);
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 send(3);
    repeat (3) @(posedge clk);
    #1 chk("drain_flush", q.size(), 0);
    ready_i = 1'b0;
    send(12);
`ifdef RV_DECODE_SKID_EN
    send(9);
`endif
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_payload", {pc_o, imm_o, fmt_o, illegal_o}, 0);
    q.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 send(13);
    repeat (3) @(posedge clk);
    #1 chk("drain_final", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
